// File: rtl/multicycle_maindec_pkg.sv
// Shared types and constants for the multi-cycle MIPS main controller:
// opcodes, FSM state encoding, datapath mux codes and the control vector.
package multicycle_maindec_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StRtExe  = 4'd6,
        StRtWb   = 4'd7,
        StBr     = 4'd8,
        StIExe   = 4'd9,
        StIWb    = 4'd10,
        StJmp    = 4'd11,
        StIll    = 4'd12,
        StErr    = 4'd13
    } mc_state_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_LOGIC = 2'b11;

    localparam logic [1:0] ALUSRCB_RT    = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_BRIMM = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       zeroext;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       illegal;
        logic       mem_err;
    } ctrl_t;

endpackage

// File: rtl/multicycle_maindec_outdec.sv
// Combinational control-vector decode from FSM state and latched opcode.
// Only FETCH looks at mem_ready (IR/PC load on the completing cycle).
module multicycle_maindec_outdec
    import multicycle_maindec_pkg::*;
#(
    parameter int unsigned OP_W = 6
) (
    input  mc_state_e       i_state,
    input  logic [OP_W-1:0] i_op_q,
    input  logic            i_mem_ready,
    output ctrl_t           o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        unique case (i_state)
            StFetch: begin
                o_ctrl.mem_req = 1'b1;
                o_ctrl.alusrcb = ALUSRCB_FOUR;
                o_ctrl.aluop   = ALUOP_ADD;
                o_ctrl.irwrite = i_mem_ready;
                o_ctrl.pcwrite = i_mem_ready;
            end
            StDecode: begin
                o_ctrl.alusrcb = ALUSRCB_BRIMM;
                o_ctrl.aluop   = ALUOP_ADD;
            end
            StMemAdr: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.alusrcb = ALUSRCB_IMM;
                o_ctrl.aluop   = ALUOP_ADD;
            end
            StMemRd: begin
                o_ctrl.mem_req = 1'b1;
                o_ctrl.iord    = 1'b1;
            end
            StMemWb: begin
                o_ctrl.memtoreg = 1'b1;
                o_ctrl.regwrite = 1'b1;
            end
            StMemWr: begin
                o_ctrl.mem_req  = 1'b1;
                o_ctrl.iord     = 1'b1;
                o_ctrl.memwrite = 1'b1;
            end
            StRtExe: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.alusrcb = ALUSRCB_RT;
                o_ctrl.aluop   = ALUOP_FUNCT;
            end
            StRtWb: begin
                o_ctrl.regdst   = 1'b1;
                o_ctrl.regwrite = 1'b1;
            end
            StBr: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.alusrcb = ALUSRCB_RT;
                o_ctrl.aluop   = ALUOP_SUB;
                o_ctrl.pcsrc   = PCSRC_ALUOUT;
                o_ctrl.branch  = 1'b1;
            end
            StIExe: begin
                o_ctrl.alusrca = 1'b1;
                o_ctrl.alusrcb = ALUSRCB_IMM;
                o_ctrl.aluop   = (i_op_q == OP_W'(OP_ADDI)) ? ALUOP_ADD : ALUOP_LOGIC;
                o_ctrl.zeroext = (i_op_q == OP_W'(OP_ANDI)) || (i_op_q == OP_W'(OP_ORI));
            end
            StIWb: begin
                o_ctrl.regwrite = 1'b1;
            end
            StJmp: begin
                o_ctrl.pcsrc   = PCSRC_JUMP;
                o_ctrl.pcwrite = 1'b1;
            end
            StIll: begin
                o_ctrl.illegal = 1'b1;
            end
            StErr: begin
                o_ctrl.mem_err = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_maindec.sv
// Multi-cycle MIPS main controller: state register, latched opcode,
// memory-wait watchdog and next-state logic; outputs decoded by a sub-module.
module multicycle_maindec
    import multicycle_maindec_pkg::*;
#(
    parameter int unsigned OP_W        = 6,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] op,
    input  logic            mem_ready,
    output logic            mem_req,
    output logic            iord,
    output logic            memwrite,
    output logic            irwrite,
    output logic            pcwrite,
    output logic            branch,
    output logic            regdst,
    output logic            memtoreg,
    output logic            regwrite,
    output logic            alusrca,
    output logic [1:0]      alusrcb,
    output logic            zeroext,
    output logic [1:0]      aluop,
    output logic [1:0]      pcsrc,
    output logic            illegal,
    output logic            mem_err,
    output logic [3:0]      state_o
);

    localparam int unsigned MemLimit = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;

    mc_state_e       r_state;
    mc_state_e       w_state_d;
    logic [OP_W-1:0] r_op_q;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    logic            w_waiting;
    logic            w_timeout;
    ctrl_t           w_ctrl;
    ctrl_t           w_out;

    multicycle_maindec_outdec #(
        .OP_W (OP_W)
    ) u_outdec (
        .i_state     (r_state),
        .i_op_q      (r_op_q),
        .i_mem_ready (mem_ready),
        .o_ctrl      (w_ctrl)
    );

    assign w_waiting = (MEM_TIMEOUT != 0) && w_ctrl.mem_req && !mem_ready;
    assign w_timeout = w_waiting && (r_cnt == CNT_W'(MemLimit));

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StFetch:  if (mem_ready) w_state_d = StDecode;
            StDecode: begin
                if (op == OP_W'(OP_LW) || op == OP_W'(OP_SW)) begin
                    w_state_d = StMemAdr;
                end else if (op == OP_W'(OP_RTYPE)) begin
                    w_state_d = StRtExe;
                end else if (op == OP_W'(OP_BEQ)) begin
                    w_state_d = StBr;
                end else if (op == OP_W'(OP_ADDI) || op == OP_W'(OP_ANDI) ||
                             op == OP_W'(OP_ORI)  || op == OP_W'(OP_LUI)) begin
                    w_state_d = StIExe;
                end else if (op == OP_W'(OP_J)) begin
                    w_state_d = StJmp;
                end else begin
                    w_state_d = StIll;
                end
            end
            StMemAdr: w_state_d = (r_op_q == OP_W'(OP_LW)) ? StMemRd : StMemWr;
            StMemRd:  if (mem_ready) w_state_d = StMemWb;
            StMemWr:  if (mem_ready) w_state_d = StFetch;
            StRtExe:  w_state_d = StRtWb;
            StIExe:   w_state_d = StIWb;
            StMemWb, StRtWb, StBr, StIWb, StJmp, StIll: w_state_d = StFetch;
            StErr:    w_state_d = StErr;
            default:  w_state_d = StFetch;
        endcase
        if (w_timeout) w_state_d = StErr;
    end

    // Any state change clears the count, so each memory wait starts from zero.
    always_comb begin
        w_cnt_d = r_cnt;
        if (w_state_d != r_state) begin
            w_cnt_d = '0;
        end else if (w_waiting) begin
            w_cnt_d = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StFetch;
            r_op_q  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            if (r_state == StDecode) r_op_q <= op;
        end
    end

    // Gate with rst so no strobe escapes while reset is held.
    assign w_out    = rst ? '0 : w_ctrl;
    assign state_o  = rst ? 4'd0 : r_state;

    assign mem_req  = w_out.mem_req;
    assign iord     = w_out.iord;
    assign memwrite = w_out.memwrite;
    assign irwrite  = w_out.irwrite;
    assign pcwrite  = w_out.pcwrite;
    assign branch   = w_out.branch;
    assign regdst   = w_out.regdst;
    assign memtoreg = w_out.memtoreg;
    assign regwrite = w_out.regwrite;
    assign alusrca  = w_out.alusrca;
    assign alusrcb  = w_out.alusrcb;
    assign zeroext  = w_out.zeroext;
    assign aluop    = w_out.aluop;
    assign pcsrc    = w_out.pcsrc;
    assign illegal  = w_out.illegal;
    assign mem_err  = w_out.mem_err;

endmodule
